// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the ALU: register file, pending scoreboard, hazard stall,
// and a registered select/a/b/rd output with valid/ready handshakes on both sides.
module alu_operand_stage #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REG_COUNT = 8,
  parameter int unsigned ADDR_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_imm_en,
  input  logic [WIDTH-1:0]  in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        select,
  output logic [WIDTH-1:0]  a,
  output logic [WIDTH-1:0]  b,
  output logic [ADDR_W-1:0] out_rd,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              busy
);

  logic [WIDTH-1:0]     r_regs [REG_COUNT];
  logic [REG_COUNT-1:0] r_pending;
  logic                 r_busy;
  logic                 r_out_valid;
  logic [2:0]           r_select;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [ADDR_W-1:0]    r_out_rd;

  logic                 w_unary;
  logic [REG_COUNT-1:0] w_wb_clr;
  logic [REG_COUNT-1:0] w_pend_eff;
  logic [REG_COUNT-1:0] w_set;
  logic [REG_COUNT-1:0] w_pend_next;
  logic                 w_hazard;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_rs1_val;
  logic [WIDTH-1:0]     w_rs2_val;
  logic [WIDTH-1:0]     w_b_next;

  // Hazard detection; a same-cycle writeback already resolves its register.
  always_comb begin
    w_unary  = in_op[2];
    w_wb_clr = '0;
    if (wb_en) w_wb_clr[wb_rd] = 1'b1;
    w_pend_eff = r_pending & ~w_wb_clr;
    w_hazard   = w_pend_eff[in_rs1]
               | (w_pend_eff[in_rs2] & ~w_unary & ~in_imm_en)
               | w_pend_eff[in_rd];
    in_ready = !rst && (!r_out_valid || out_ready) && !w_hazard;
    w_accept = in_valid && in_ready;
    w_set    = '0;
    if (w_accept && (in_rd != '0)) w_set[in_rd] = 1'b1;
    w_pend_next = w_pend_eff | w_set;
  end

  // Operand read with writeback bypass; register 0 is hard zero.
  always_comb begin
    w_rs1_val = r_regs[in_rs1];
    if (wb_en && (wb_rd == in_rs1)) w_rs1_val = wb_data;
    if (in_rs1 == '0) w_rs1_val = '0;
    w_rs2_val = r_regs[in_rs2];
    if (wb_en && (wb_rd == in_rs2)) w_rs2_val = wb_data;
    if (in_rs2 == '0) w_rs2_val = '0;
    if (in_imm_en)    w_b_next = in_imm;
    else if (w_unary) w_b_next = '0;
    else              w_b_next = w_rs2_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs      <= '{default: '0};
      r_pending   <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_select    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_out_rd    <= '0;
    end else begin
      if (wb_en && (wb_rd != '0)) r_regs[wb_rd] <= wb_data;
      r_pending <= w_pend_next;
      r_busy    <= |w_pend_next;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_select    <= in_op;
        r_a         <= w_rs1_val;
        r_b         <= w_b_next;
        r_out_rd    <= in_rd;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign select    = r_select;
  assign a         = r_a;
  assign b         = r_b;
  assign out_rd    = r_out_rd;
  assign busy      = r_busy;

endmodule
